pe_seq_ctrl: RTL

Sequencer between the ifmap/filter operand stream and a single processing element (PE). For each output it latches a job (kernel size, output count, initial psum) and streams exactly kernel_size (ifmap, fltr) pairs into the PE under ready/valid. It then waits for the PE result and hands each partial sum downstream. A watchdog flags a PE that never returns a result.

---
 rtl/pe_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one PE: streams kernel_size operand pairs per output, then waits (with watchdog) for the PE result.
// Latency kernel_size+2 cycles per output minimum; in_ready follows PE_READY in LOAD, result held until out_ready.
module pe_seq_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_KERNEL  = 9,
    parameter int MAX_OUTPUTS = 256,
    parameter int TIMEOUT     = 64,
    localparam int KW = $clog2(MAX_KERNEL + 1),
    localparam int OW = $clog2(MAX_OUTPUTS + 1),
    localparam int PW = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         cfg_kernel_size,
    input  logic [OW-1:0]         cfg_num_outputs,
    input  logic [PW-1:0]         cfg_psum_init,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_ifmap,
    input  logic [DATA_WIDTH-1:0] in_fltr,
    output logic [DATA_WIDTH-1:0] ifmap_data_M2P,
    output logic [DATA_WIDTH-1:0] fltr_data_M2P,
    output logic [PW-1:0]         psum_data_M2P,
    output logic [KW-1:0]         kernel_size,
    output logic                  PE_EN,
    input  logic                  PE_READY,
    input  logic                  PE_VALID,
    input  logic [PW-1:0]         psum_data_P2M,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PW-1:0]         out_psum,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] K_MAX  = KW'(MAX_KERNEL);
    localparam logic [OW-1:0] N_MAX  = OW'(MAX_OUTPUTS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] ks_q, ks_d;
    logic [KW-1:0] pair_cnt_q, pair_cnt_d;
    logic [OW-1:0] nout_q, nout_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PW-1:0] psum_init_q, psum_init_d;
    logic [PW-1:0] out_psum_q, out_psum_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cfg_ok;
    logic          pair_xfer;

    assign cfg_ok = (cfg_kernel_size != '0) && (cfg_kernel_size <= K_MAX) &&
                    (cfg_num_outputs != '0) && (cfg_num_outputs <= N_MAX);

    // Operand path is purely combinational so a pair costs no extra cycle.
    assign in_ready       = (state_q == S_LOAD) && PE_READY;
    assign PE_EN          = (state_q == S_LOAD) && in_valid;
    assign pair_xfer      = in_valid && in_ready;
    assign ifmap_data_M2P = in_ifmap;
    assign fltr_data_M2P  = in_fltr;

    assign psum_data_M2P = psum_init_q;
    assign kernel_size   = ks_q;
    assign out_valid     = (state_q == S_OUT);
    assign out_psum      = out_psum_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        state_d     = state_q;
        ks_d        = ks_q;
        pair_cnt_d  = pair_cnt_q;
        nout_d      = nout_q;
        out_cnt_d   = out_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        psum_init_d = psum_init_q;
        out_psum_d  = out_psum_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d     = S_LOAD;
                        ks_d        = cfg_kernel_size;
                        nout_d      = cfg_num_outputs;
                        psum_init_d = cfg_psum_init;
                        pair_cnt_d  = '0;
                        out_cnt_d   = '0;
                        wait_cnt_d  = '0;
                        err_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (pair_xfer) begin
                    if (pair_cnt_q == ks_q - 1'b1) begin
                        pair_cnt_d = '0;
                        wait_cnt_d = '0;
                        state_d    = S_WAIT;
                    end else begin
                        pair_cnt_d = pair_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // A result on the last watchdog cycle still wins over the abort.
                if (PE_VALID) begin
                    out_psum_d = psum_data_P2M;
                    wait_cnt_d = '0;
                    state_d    = S_OUT;
                end else if (wait_cnt_q == T_LAST) begin
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == nout_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ks_q        <= '0;
            pair_cnt_q  <= '0;
            nout_q      <= '0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            psum_init_q <= '0;
            out_psum_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ks_q        <= ks_d;
            pair_cnt_q  <= pair_cnt_d;
            nout_q      <= nout_d;
            out_cnt_q   <= out_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            psum_init_q <= psum_init_d;
            out_psum_q  <= out_psum_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
